int_controller: RTL and testbench
=================================

INT_CONTROLLER -- requirements
Module: int_controller

Interface
REQ-001 Parameter ADDR_W, default 10, width of program-memory addresses and vector outputs.
REQ-002 Parameter VEC_BASE, default 10'h3F0, base address of the interrupt vector table.
REQ-003 Parameter TIMER_PERIOD, default 16'd1000, timer interrupt period in clk cycles; legal range 2..65535.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 i_except  input  1  exception event, 1-cycle pulse; source 0, highest priority, non-maskable.
REQ-007 i_syscall  input  1  syscall event, 1-cycle pulse; source 1.
REQ-008 i_port  input  1  I/O port event, 1-cycle pulse; source 2.
REQ-009 timer_en  input  1  internal timer enable; the timer is source 3, lowest priority.
REQ-010 mask_we  input  1  write strobe for the mask register.
REQ-011 mask_in  input  4  new mask value; bit n=1 enables source n.
REQ-012 s_ack  input  1  control unit accepts the request at an instruction boundary.
REQ-013 s_finished  input  1  return-from-interrupt executed, 1-cycle pulse.
REQ-014 s_interruption  output  1  interrupt request to the control unit.
REQ-015 dir_from_exception  output  ADDR_W  vector address of the granted source.
REQ-016 cause  output  2  id of the granted source.
REQ-017 in_service  output  1  handler currently running.
REQ-018 pending  output  4  pending flags, bit n = source n.

Function
REQ-019 The FSM SHALL have three states: IDLE, REQUEST, SERVICE.
REQ-020 The pending[n] flag SHALL set on the edge where source n is sampled high; the set wins over a same-cycle clear.
REQ-021 The eligible set SHALL be pending & {mask[3:1], 1'b1}; mask bit 0 is ignored.
REQ-022 In IDLE with a non-empty eligible set, the FSM SHALL go to REQUEST on the next edge and latch cause as the lowest eligible index.
REQ-023 In REQUEST, s_interruption SHALL be 1 and cause SHALL stay frozen; a higher-priority arrival does not preempt it.
REQ-024 In REQUEST with s_ack=1, the FSM SHALL go to SERVICE and clear pending[cause] on the same edge.
REQ-025 In SERVICE, in_service SHALL be 1 and s_interruption 0; there is no nesting, and new events only accumulate in pending.
REQ-026 In SERVICE with s_finished=1, the FSM SHALL go to IDLE.
REQ-027 s_finished outside SERVICE SHALL be ignored, and s_ack outside REQUEST SHALL be ignored.
REQ-028 dir_from_exception SHALL equal VEC_BASE + {cause, 2'b00}, truncated modulo 2^ADDR_W, and is valid in REQUEST and SERVICE.
REQ-029 Latency SHALL be as follows: event sampled at edge k -> pending set after k -> s_interruption high after edge k+1, provided the FSM is IDLE and the source is unmasked.
REQ-030 The mask register SHALL load on mask_we in any state.
REQ-031 Masking a source that is latched in REQUEST SHALL NOT withdraw the request.
REQ-032 Masking a source SHALL NOT clear its pending flag.
REQ-033 The timer SHALL be a 16-bit counter that increments while timer_en=1.
REQ-034 At count TIMER_PERIOD-1 the timer SHALL wrap to 0 and set pending[3].
REQ-035 timer_en=0 SHALL clear the count to 0 synchronously.
REQ-036 If s_finished and an eligible pending coincide in SERVICE, the FSM SHALL go to IDLE and then to REQUEST on the following edge.

Reset
REQ-037 While reset=1, the block SHALL asynchronously force state=IDLE, pending=0, mask=4'b0000, cause=0, timer count=0, s_interruption=0 and in_service=0.
REQ-038 While reset=1, dir_from_exception SHALL equal VEC_BASE.
REQ-039 Reset asserted in REQUEST or SERVICE SHALL abort the request or handler and discard all pending events.
REQ-040 The first post-reset edge SHALL sample sources normally.

Verification
REQ-041 mask=4'b0100; i_port pulse at edge k -> s_interruption=1 after k+1, cause=2, dir_from_exception=10'h3F8; s_ack -> in_service=1, pending=0; s_finished -> IDLE.
REQ-042 mask=4'b1110; i_port and i_syscall pulse on the same edge -> grant cause=1 (10'h3F4); after s_finished -> cause=2 is granted.
REQ-043 mask=0; i_except pulse -> granted with cause=0 and dir_from_exception=10'h3F0; i_syscall pulse stays pending and is never requested.
REQ-044 TIMER_PERIOD=4, mask=4'b1000, timer_en=1 -> pending[3] sets every 4 cycles.
REQ-045 Same setup as REQ-044, with a second timer tick during SERVICE -> the tick is held pending and re-requested immediately after s_finished.
REQ-046 In REQUEST, i_except pulses without s_ack -> cause is unchanged; then assert reset mid-SERVICE -> all outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/int_controller.sv
// int_controller: four-source prioritised interrupt controller.
// Sources: 0 = exception (non-maskable), 1 = syscall, 2 = I/O port,
// 3 = internal periodic timer. One request is in flight at a time; events
// arriving while a request or handler is active accumulate in pending.
module int_controller #(
   parameter int                ADDR_W       = 10,
   parameter logic [ADDR_W-1:0] VEC_BASE     = 10'h3F0,
   parameter logic [15:0]       TIMER_PERIOD = 16'd1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_except,
   input  logic              i_syscall,
   input  logic              i_port,
   input  logic              timer_en,
   input  logic              mask_we,
   input  logic [3:0]        mask_in,
   input  logic              s_ack,
   input  logic              s_finished,
   output logic              s_interruption,
   output logic [ADDR_W-1:0] dir_from_exception,
   output logic [1:0]        cause,
   output logic              in_service,
   output logic [3:0]        pending
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic [3:0]  mask_r;
   logic [15:0] count_r;
   logic        tick_s;
   logic [3:0]  set_s;
   logic [3:0]  clr_s;
   logic [3:0]  eligible_s;
   logic [3:0]  pending_s;
   logic [1:0]  cause_s;

   // Lowest set index wins: source 0 has the highest priority.
   function automatic logic [1:0] lowest_index(input logic [3:0] req);
      logic [1:0] idx;
      idx = 2'd0;
      for (int n = 3; n >= 0; n--) begin
         if (req[n]) begin
            idx = 2'(n);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Vector table entries are four words apart; the sum wraps at 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] vector_addr(input logic [1:0] c);
      return VEC_BASE + ADDR_W'({c, 2'b00});
   endfunction

   assign tick_s = timer_en && (count_r == (TIMER_PERIOD - 16'd1));

   // Timer counter: counts while enabled, wraps on the tick, held at zero when disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= 16'd0;
      end else if (!timer_en) begin
         count_r <= 16'd0;
      end else if (tick_s) begin
         count_r <= 16'd0;
      end else begin
         count_r <= count_r + 16'd1;
      end
   end

   // Source sampling and eligibility; mask bit 0 is forced on so the exception cannot be masked.
   always_comb begin
      set_s      = {tick_s, i_port, i_syscall, i_except};
      eligible_s = pending & (mask_r | 4'b0001);
   end

   // Next-state logic: grant selection, acknowledge-time clear, return from handler.
   always_comb begin
      state_s = state_r;
      cause_s = cause;
      clr_s   = 4'b0000;
      case (state_r)
         IDLE: begin
            if (|eligible_s) begin
               state_s = REQUEST;
               cause_s = lowest_index(eligible_s);
            end else begin
               state_s = IDLE;
            end
         end
         REQUEST: begin
            if (s_ack) begin
               state_s = SERVICE;
               clr_s   = 4'b0001 << cause;
            end else begin
               state_s = REQUEST;
            end
         end
         SERVICE: begin
            if (s_finished) begin
               state_s = IDLE;
            end else begin
               state_s = SERVICE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      // A new event on the same edge as its clear keeps the flag set.
      pending_s = (pending & ~clr_s) | set_s;
   end

   // State, pending flags, mask and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r            <= IDLE;
         pending            <= 4'b0000;
         mask_r             <= 4'b0000;
         cause              <= 2'd0;
         s_interruption     <= 1'b0;
         in_service         <= 1'b0;
         dir_from_exception <= VEC_BASE;
      end else begin
         state_r            <= state_s;
         pending            <= pending_s;
         mask_r             <= mask_we ? mask_in : mask_r;
         cause              <= cause_s;
         s_interruption     <= (state_s == REQUEST);
         in_service         <= (state_s == SERVICE);
         dir_from_exception <= vector_addr(cause_s);
      end
   end

endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the interrupt rules.
module tb_int_controller;

   localparam int PERIOD = 4;
   localparam int VEC    = 1008;   // 10'h3F0

   logic       clk;
   logic       reset;
   logic       i_except;
   logic       i_syscall;
   logic       i_port;
   logic       timer_en;
   logic       mask_we;
   logic [3:0] mask_in;
   logic       s_ack;
   logic       s_finished;
   logic       s_interruption;
   logic [9:0] dir_from_exception;
   logic [1:0] cause;
   logic       in_service;
   logic [3:0] pending;

   int n_checks;
   int n_fail;

   // reference model: phase 0 = idle, 1 = request, 2 = service
   int       m_phase;
   int       m_cause;
   bit [3:0] m_pend;
   bit [3:0] m_mask;
   int       m_tcount;

   int_controller #(
      .ADDR_W      (10),
      .VEC_BASE    (10'h3F0),
      .TIMER_PERIOD(16'd4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .i_except          (i_except),
      .i_syscall         (i_syscall),
      .i_port            (i_port),
      .timer_en          (timer_en),
      .mask_we           (mask_we),
      .mask_in           (mask_in),
      .s_ack             (s_ack),
      .s_finished        (s_finished),
      .s_interruption    (s_interruption),
      .dir_from_exception(dir_from_exception),
      .cause             (cause),
      .in_service        (in_service),
      .pending           (pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_phase  = 0;
      m_cause  = 0;
      m_pend   = 4'b0000;
      m_mask   = 4'b0000;
      m_tcount = 0;
   endtask

   // Advance the model by one edge with the current inputs, then step the DUT.
   task automatic tick();
      bit       tmr;
      bit [3:0] elig;
      int       lo;
      tmr = timer_en && (m_tcount == PERIOD - 1);
      m_tcount = timer_en ? (m_tcount + 1) % PERIOD : 0;
      for (int n = 0; n < 4; n++) elig[n] = m_pend[n] && (n == 0 || m_mask[n]);
      if (m_phase == 0) begin
         if (elig != 4'b0000) begin
            lo = 3;
            for (int n = 3; n >= 0; n--) if (elig[n]) lo = n;
            m_phase = 1;
            m_cause = lo;
         end
      end else if (m_phase == 1) begin
         if (s_ack) begin
            m_phase = 2;
            m_pend[m_cause] = 1'b0;
         end
      end else begin
         if (s_finished) m_phase = 0;
      end
      if (i_except)  m_pend[0] = 1'b1;
      if (i_syscall) m_pend[1] = 1'b1;
      if (i_port)    m_pend[2] = 1'b1;
      if (tmr)       m_pend[3] = 1'b1;
      if (mask_we)   m_mask = mask_in;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_except = 1'b0; i_syscall = 1'b0; i_port = 1'b0; timer_en = 1'b0;
      mask_we = 1'b0; mask_in = 4'b0000; s_ack = 1'b0; s_finished = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic set_mask(input logic [3:0] m);
      mask_we = 1'b1; mask_in = m;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      n_checks++; if (s_interruption !== 1'b0) begin n_fail++; $display("FAIL rst_int: got %0b want 0", s_interruption); end
      n_checks++; if (in_service !== 1'b0) begin n_fail++; $display("FAIL rst_svc: got %0b want 0", in_service); end
      n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL rst_pend: got %b want 0000", pending); end
      n_checks++; if (cause !== 2'd0) begin n_fail++; $display("FAIL rst_cause: got %0d want 0", cause); end
      n_checks++; if (dir_from_exception !== 10'h3F0) begin n_fail++; $display("FAIL rst_dir: got %h want 3f0", dir_from_exception); end
      reset = 1'b0;
      // first edge after reset samples sources normally
      i_syscall = 1'b1;
      tick();
      i_syscall = 1'b0;
      n_checks++; if (pending !== 4'b0010) begin n_fail++; $display("FAIL rst_first_edge: got %b want 0010", pending); end
      do_reset();
   endtask

   task automatic test_single_port();
      set_mask(4'b0100);
      i_port = 1'b1;
      tick();
      i_port = 1'b0;
      n_checks++; if (pending !== 4'b0100 || s_interruption !== 1'b0) begin n_fail++; $display("FAIL port_k: got pend=%b int=%0b want 0100/0", pending, s_interruption); end
      tick();
      n_checks++; if (s_interruption !== 1'b1 || cause !== 2'd2) begin n_fail++; $display("FAIL port_req: got int=%0b cause=%0d want 1/2", s_interruption, cause); end
      n_checks++; if (dir_from_exception !== 10'h3F8) begin n_fail++; $display("FAIL port_dir: got %h want 3f8", dir_from_exception); end
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      n_checks++; if (in_service !== 1'b1 || pending !== 4'b0000 || s_interruption !== 1'b0) begin n_fail++; $display("FAIL port_svc: got svc=%0b pend=%b int=%0b want 1/0000/0", in_service, pending, s_interruption); end
      s_finished = 1'b1;
      tick();
      s_finished = 1'b0;
      n_checks++; if (in_service !== 1'b0 || s_interruption !== 1'b0) begin n_fail++; $display("FAIL port_idle: got svc=%0b int=%0b want 0/0", in_service, s_interruption); end
   endtask

   task automatic test_priority();
      set_mask(4'b1110);
      i_port = 1'b1; i_syscall = 1'b1;
      tick();
      i_port = 1'b0; i_syscall = 1'b0;
      tick();
      n_checks++; if (s_interruption !== 1'b1 || cause !== 2'd1 || dir_from_exception !== 10'h3F4) begin n_fail++; $display("FAIL prio_first: got int=%0b cause=%0d dir=%h want 1/1/3f4", s_interruption, cause, dir_from_exception); end
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("FAIL prio_pend: got %b want 0100", pending); end
      s_finished = 1'b1;
      tick();
      s_finished = 1'b0;
      n_checks++; if (s_interruption !== 1'b0 || in_service !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got int=%0b svc=%0b want 0/0", s_interruption, in_service); end
      tick();
      n_checks++; if (s_interruption !== 1'b1 || cause !== 2'd2) begin n_fail++; $display("FAIL prio_second: got int=%0b cause=%0d want 1/2", s_interruption, cause); end
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      s_finished = 1'b1; tick(); s_finished = 1'b0;
   endtask

   task automatic test_mask_zero();
      set_mask(4'b0000);
      i_except = 1'b1;
      tick();
      i_except = 1'b0;
      tick();
      n_checks++; if (s_interruption !== 1'b1 || cause !== 2'd0 || dir_from_exception !== 10'h3F0) begin n_fail++; $display("FAIL nmi_req: got int=%0b cause=%0d dir=%h want 1/0/3f0", s_interruption, cause, dir_from_exception); end
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      s_finished = 1'b1; tick(); s_finished = 1'b0;
      i_syscall = 1'b1;
      tick();
      i_syscall = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_checks++; if (s_interruption !== 1'b0 || pending !== 4'b0010) begin n_fail++; $display("FAIL masked_hold: got int=%0b pend=%b want 0/0010", s_interruption, pending); end
      do_reset();
   endtask

   task automatic test_timer();
      set_mask(4'b1000);
      timer_en = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      n_checks++; if (pending[3] !== 1'b0) begin n_fail++; $display("FAIL tmr_early: got %0b want 0", pending[3]); end
      tick();
      n_checks++; if (pending[3] !== 1'b1 || s_interruption !== 1'b0) begin n_fail++; $display("FAIL tmr_tick: got pend3=%0b int=%0b want 1/0", pending[3], s_interruption); end
      tick();
      n_checks++; if (s_interruption !== 1'b1 || cause !== 2'd3 || dir_from_exception !== 10'h3FC) begin n_fail++; $display("FAIL tmr_req: got int=%0b cause=%0d dir=%h want 1/3/3fc", s_interruption, cause, dir_from_exception); end
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      n_checks++; if (in_service !== 1'b1 || pending[3] !== 1'b0) begin n_fail++; $display("FAIL tmr_ack: got svc=%0b pend3=%0b want 1/0", in_service, pending[3]); end
      tick();
      tick();
      n_checks++; if (pending[3] !== 1'b1 || in_service !== 1'b1 || s_interruption !== 1'b0) begin n_fail++; $display("FAIL tmr_svc_tick: got pend3=%0b svc=%0b int=%0b want 1/1/0", pending[3], in_service, s_interruption); end
      s_finished = 1'b1; tick(); s_finished = 1'b0;
      n_checks++; if (in_service !== 1'b0 || s_interruption !== 1'b0) begin n_fail++; $display("FAIL tmr_ret: got svc=%0b int=%0b want 0/0", in_service, s_interruption); end
      tick();
      n_checks++; if (s_interruption !== 1'b1 || cause !== 2'd3) begin n_fail++; $display("FAIL tmr_rereq: got int=%0b cause=%0d want 1/3", s_interruption, cause); end
      timer_en = 1'b0;
      do_reset();
   endtask

   task automatic test_no_preempt_reset();
      set_mask(4'b0100);
      i_port = 1'b1; tick(); i_port = 1'b0;
      tick();
      i_except = 1'b1; tick(); i_except = 1'b0;
      tick();
      n_checks++; if (cause !== 2'd2 || s_interruption !== 1'b1 || pending !== 4'b0101) begin n_fail++; $display("FAIL no_preempt: got cause=%0d int=%0b pend=%b want 2/1/0101", cause, s_interruption, pending); end
      set_mask(4'b0000);
      n_checks++; if (s_interruption !== 1'b1 || cause !== 2'd2) begin n_fail++; $display("FAIL mask_in_req: got int=%0b cause=%0d want 1/2", s_interruption, cause); end
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      n_checks++; if (in_service !== 1'b1) begin n_fail++; $display("FAIL pre_rst_svc: got %0b want 1", in_service); end
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      n_checks++; if (in_service !== 1'b0 || s_interruption !== 1'b0 || pending !== 4'b0000 || cause !== 2'd0 || dir_from_exception !== 10'h3F0) begin
         n_fail++; $display("FAIL async_rst: got svc=%0b int=%0b pend=%b cause=%0d dir=%h", in_service, s_interruption, pending, cause, dir_from_exception);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_random();
      logic [19:0] got;
      logic [19:0] exp;
      int          bad;
      bad = 0;
      for (int i = 0; i < 600; i++) begin
         i_except   = ($urandom_range(0, 19) == 0);
         i_syscall  = ($urandom_range(0, 9) == 0);
         i_port     = ($urandom_range(0, 9) == 0);
         timer_en   = ($urandom_range(0, 3) != 0);
         mask_we    = ($urandom_range(0, 15) == 0);
         mask_in    = 4'($urandom_range(0, 15));
         s_ack      = ($urandom_range(0, 2) == 0);
         s_finished = ($urandom_range(0, 3) == 0);
         tick();
         exp = {m_phase == 1, m_phase == 2, 2'(m_cause), m_pend, 10'((VEC + m_cause * 4) % 1024), 2'b00};
         got = {s_interruption, in_service, cause, pending, dir_from_exception, 2'b00};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            if (bad < 10) $display("FAIL rand_cycle%0d: got %h want %h", i, got, exp);
            bad++;
         end
      end
      clear_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      clear_inputs();
      model_reset();
      test_reset();
      test_single_port();
      test_priority();
      test_mask_zero();
      test_timer();
      test_no_preempt_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
